rob_retire: RTL and testbench
=============================

// Module: rob_retire
// PURPOSE
//   16-entry circular reorder buffer, 2-wide allocate and 2-wide in-order retire.
//   Dispatch writes each renamed instruction's pd/old_pd/pc at the tail.
//   FU writeback marks entries done; retire drains done entries from the head.
//   Retired old_pd values go back to the free pool / RAT logic.
// PARAMETERS
//   ROB_DEPTH  16  entries; power of two; index width = $clog2(ROB_DEPTH) = 4
//   PREG_W     6   physical register tag width (64 physical regs)
//   PC_W       32  program counter width
// PORTS
//   clk            in   1   rising-edge clock
//   rst_n          in   1   asynchronous active-low reset
//   alloc_valid_1  in   1   allocate slot 1 (older of the pair)
//   alloc_pd_1     in   6   new physical dest, slot 1
//   alloc_old_pd_1 in   6   previous mapping of rd, slot 1
//   alloc_pc_1     in   32  PC, slot 1
//   alloc_valid_2, alloc_pd_2, alloc_old_pd_2, alloc_pc_2  in  1/6/6/32  same, slot 2 (younger)
//   alloc_ready    out  1   >=2 free entries (comb. from count)
//   alloc_idx_1    out  4   ROB index slot 1 receives (= tail)
//   alloc_idx_2    out  4   ROB index slot 2 receives (= tail+1 if slot 1 used, else tail)
//   cmpl_valid_a   in   1   FU writeback port A
//   cmpl_idx_a     in   4   ROB index completed on port A
//   cmpl_valid_b   in   1   FU writeback port B
//   cmpl_idx_b     in   4   ROB index completed on port B
//   ret_valid_1    out  1   head entry retired this cycle (registered)
//   ret_pd_1       out  6   retired entry's pd
//   ret_old_pd_1   out  6   tag to return to the free pool
//   ret_pc_1       out  32  retired PC
//   ret_valid_2, ret_pd_2, ret_old_pd_2, ret_pc_2  out  1/6/6/32  second retire slot
//   rob_count      out  5   occupied entries, 0..16
//   alloc_overflow out  1   sticky: allocation attempted while alloc_ready=0
// BEHAVIOUR
//   Reset (async, rst_n=0): all entries v=0 and done=0; head=tail=0; count=0.
//     All ret_* outputs and alloc_overflow go to 0. alloc_ready=1; alloc_idx_1=0, alloc_idx_2=0.
//   Entry fields: v, done, pd, old_pd, pc.
//   Allocate (edge, only if alloc_ready=1):
//     Slot 1 writes tail; slot 2 writes next free index. Each written entry gets v=1, done=0.
//     Tail advances by the number of valid slots; alloc_valid_2 alone is legal.
//   If alloc_ready=0: the request is dropped, no state changes, alloc_overflow is set until reset.
//   Complete (edge): sets done=1 for cmpl_idx_a and/or cmpl_idx_b if that entry has v=1.
//     Completion of an entry with v=0 is ignored. Ports A and B on the same index is harmless.
//   Retire (edge): uses done/v values registered before this edge.
//     Slot 1 fires if head has v=1 and done=1.
//     Slot 2 fires only if slot 1 fires and head+1 has v=1 and done=1.
//     Each retired entry is cleared to v=0. Head advances by 0/1/2 modulo 16.
//     ret_* outputs are registered and valid for exactly one cycle. ret_valid_2=1 implies ret_valid_1=1.
//     If ret_valid_x=0, its data outputs hold 0.
//   Latency: completion sampled at edge N -> ret_valid at edge N+1 at the earliest, if the entry is at head.
//   Count: count_next = count + allocs - retires; simultaneous alloc and retire are both honoured.
//     alloc_ready = (count <= 14), using current count only. A retire in this cycle does not
//     raise alloc_ready until the next cycle.
//   Wrap-around: head and tail are 4-bit and wrap 15->0.
//     Full vs empty is resolved by count (16 vs 0), never by head==tail.
//   Out-of-order completion: a younger done entry never retires past an older not-done entry.
//   No flush/mispredict support in this block.
// TESTING
//   Reset: rst_n=0 mid-run with 5 entries live -> ret_valid_*=0 immediately, rob_count=0,
//     alloc_ready=1, alloc_overflow=0.
//   Pair ordering: alloc (pd32,old5,pc0),(pd33,old6,pc4); complete idx1, then idx0 a cycle later.
//     -> No retire after the idx1 completion.
//     -> One cycle after the idx0 completion: ret_valid_1=ret_valid_2=1, ret_old_pd_1=5,
//        ret_old_pd_2=6, ret_pc_2=4.
//   Full: 8 dual allocs with no completions -> alloc_ready=0 once count=16.
//     9th alloc -> dropped, rob_count stays 16, alloc_overflow=1.
//   Wrap: head=15 with entries 15 and 0 done -> both retire in one cycle, head=1, alloc_idx_1 unaffected.
//   Simultaneous: count=10, 2 allocs and 2 retires on the same edge -> rob_count=10,
//     tail+2, head+2.
//   Stray completion: cmpl_idx_a=7 with entry 7 v=0 -> no state change. A later alloc into
//     entry 7 -> done=0, no retire.

Source files
------------

// File: rtl/rob_retire_if.sv
// Signal bundle between the rename/dispatch/writeback side (master) and the
// reorder buffer (slave): allocate pair, two completion ports, retire pair, status.
interface rob_retire_if #(
  parameter int ROB_DEPTH = 16,
  parameter int PREG_W    = 6,
  parameter int PC_W      = 32
);
  localparam int IDX_W = $clog2(ROB_DEPTH);
  localparam int CNT_W = $clog2(ROB_DEPTH + 1);

  // Allocation handshake: a slot is accepted on a rising edge when its alloc_valid_x
  // is high and alloc_ready is high in that same cycle. A request seen while
  // alloc_ready is low is dropped (never held) and raises alloc_overflow.
  logic              alloc_valid_1;
  logic [PREG_W-1:0] alloc_pd_1;
  logic [PREG_W-1:0] alloc_old_pd_1;
  logic [PC_W-1:0]   alloc_pc_1;
  logic              alloc_valid_2;
  logic [PREG_W-1:0] alloc_pd_2;
  logic [PREG_W-1:0] alloc_old_pd_2;
  logic [PC_W-1:0]   alloc_pc_2;
  logic              alloc_ready;
  logic [IDX_W-1:0]  alloc_idx_1;
  logic [IDX_W-1:0]  alloc_idx_2;

  logic              cmpl_valid_a;
  logic [IDX_W-1:0]  cmpl_idx_a;
  logic              cmpl_valid_b;
  logic [IDX_W-1:0]  cmpl_idx_b;

  logic              ret_valid_1;
  logic [PREG_W-1:0] ret_pd_1;
  logic [PREG_W-1:0] ret_old_pd_1;
  logic [PC_W-1:0]   ret_pc_1;
  logic              ret_valid_2;
  logic [PREG_W-1:0] ret_pd_2;
  logic [PREG_W-1:0] ret_old_pd_2;
  logic [PC_W-1:0]   ret_pc_2;

  logic [CNT_W-1:0]  rob_count;
  logic              alloc_overflow;

  modport master (
    output alloc_valid_1, alloc_pd_1, alloc_old_pd_1, alloc_pc_1,
    output alloc_valid_2, alloc_pd_2, alloc_old_pd_2, alloc_pc_2,
    output cmpl_valid_a, cmpl_idx_a, cmpl_valid_b, cmpl_idx_b,
    input  alloc_ready, alloc_idx_1, alloc_idx_2,
    input  ret_valid_1, ret_pd_1, ret_old_pd_1, ret_pc_1,
    input  ret_valid_2, ret_pd_2, ret_old_pd_2, ret_pc_2,
    input  rob_count, alloc_overflow
  );

  modport slave (
    input  alloc_valid_1, alloc_pd_1, alloc_old_pd_1, alloc_pc_1,
    input  alloc_valid_2, alloc_pd_2, alloc_old_pd_2, alloc_pc_2,
    input  cmpl_valid_a, cmpl_idx_a, cmpl_valid_b, cmpl_idx_b,
    output alloc_ready, alloc_idx_1, alloc_idx_2,
    output ret_valid_1, ret_pd_1, ret_old_pd_1, ret_pc_1,
    output ret_valid_2, ret_pd_2, ret_old_pd_2, ret_pc_2,
    output rob_count, alloc_overflow
  );
endinterface

// File: rtl/rob_retire.sv
// 16-entry circular reorder buffer: 2-wide allocate at the tail, two completion
// ports, 2-wide in-order retire from the head with registered retire outputs.
module rob_retire #(
  parameter int ROB_DEPTH = 16,
  parameter int PREG_W    = 6,
  parameter int PC_W      = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  rob_retire_if.slave  bus
);
  localparam int IDX_W = $clog2(ROB_DEPTH);
  localparam int CNT_W = $clog2(ROB_DEPTH + 1);

  logic [ROB_DEPTH-1:0] v_q, v_d, done_q, done_d;
  logic [PREG_W-1:0]    pd_q [ROB_DEPTH];
  logic [PREG_W-1:0]    pd_d [ROB_DEPTH];
  logic [PREG_W-1:0]    old_pd_q [ROB_DEPTH];
  logic [PREG_W-1:0]    old_pd_d [ROB_DEPTH];
  logic [PC_W-1:0]      pc_q [ROB_DEPTH];
  logic [PC_W-1:0]      pc_d [ROB_DEPTH];
  logic [IDX_W-1:0]     head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 ovf_q, ovf_d;

  logic                 ret_valid_1_q, ret_valid_1_d, ret_valid_2_q, ret_valid_2_d;
  logic [PREG_W-1:0]    ret_pd_1_q, ret_pd_1_d, ret_pd_2_q, ret_pd_2_d;
  logic [PREG_W-1:0]    ret_old_1_q, ret_old_1_d, ret_old_2_q, ret_old_2_d;
  logic [PC_W-1:0]      ret_pc_1_q, ret_pc_1_d, ret_pc_2_q, ret_pc_2_d;

  logic                 ready, alloc_ok, ret1, ret2;
  logic [IDX_W-1:0]     head_p1, idx1, idx2;
  logic [1:0]           n_alloc, n_ret;

  // Readiness comes from the current count only, so a same-cycle retire cannot
  // open space for a same-cycle allocation.
  assign ready   = (count_q <= CNT_W'(ROB_DEPTH - 2));
  assign head_p1 = head_q + IDX_W'(1);
  assign idx1    = tail_q;
  assign idx2    = bus.alloc_valid_1 ? tail_q + IDX_W'(1) : tail_q;

  always_comb begin
    v_d      = v_q;
    done_d   = done_q;
    pd_d     = pd_q;
    old_pd_d = old_pd_q;
    pc_d     = pc_q;
    ovf_d    = ovf_q;

    // Retire decisions look only at state registered before this edge.
    ret1    = v_q[head_q] & done_q[head_q];
    ret2    = ret1 & v_q[head_p1] & done_q[head_p1];
    n_ret   = {1'b0, ret1} + {1'b0, ret2};

    alloc_ok = ready & (bus.alloc_valid_1 | bus.alloc_valid_2);
    n_alloc  = alloc_ok ? ({1'b0, bus.alloc_valid_1} + {1'b0, bus.alloc_valid_2}) : 2'd0;
    if ((bus.alloc_valid_1 | bus.alloc_valid_2) & ~ready) ovf_d = 1'b1;

    if (bus.cmpl_valid_a && v_q[bus.cmpl_idx_a]) done_d[bus.cmpl_idx_a] = 1'b1;
    if (bus.cmpl_valid_b && v_q[bus.cmpl_idx_b]) done_d[bus.cmpl_idx_b] = 1'b1;

    if (ret1) begin
      v_d[head_q]    = 1'b0;
      done_d[head_q] = 1'b0;
    end
    if (ret2) begin
      v_d[head_p1]    = 1'b0;
      done_d[head_p1] = 1'b0;
    end

    // Allocated slots are always free entries, so they never collide with the above.
    if (alloc_ok && bus.alloc_valid_1) begin
      v_d[idx1]      = 1'b1;
      done_d[idx1]   = 1'b0;
      pd_d[idx1]     = bus.alloc_pd_1;
      old_pd_d[idx1] = bus.alloc_old_pd_1;
      pc_d[idx1]     = bus.alloc_pc_1;
    end
    if (alloc_ok && bus.alloc_valid_2) begin
      v_d[idx2]      = 1'b1;
      done_d[idx2]   = 1'b0;
      pd_d[idx2]     = bus.alloc_pd_2;
      old_pd_d[idx2] = bus.alloc_old_pd_2;
      pc_d[idx2]     = bus.alloc_pc_2;
    end

    head_d  = head_q + IDX_W'(n_ret);
    tail_d  = tail_q + IDX_W'(n_alloc);
    count_d = count_q + CNT_W'(n_alloc) - CNT_W'(n_ret);

    ret_valid_1_d = ret1;
    ret_pd_1_d    = ret1 ? pd_q[head_q]     : '0;
    ret_old_1_d   = ret1 ? old_pd_q[head_q] : '0;
    ret_pc_1_d    = ret1 ? pc_q[head_q]     : '0;
    ret_valid_2_d = ret2;
    ret_pd_2_d    = ret2 ? pd_q[head_p1]     : '0;
    ret_old_2_d   = ret2 ? old_pd_q[head_p1] : '0;
    ret_pc_2_d    = ret2 ? pc_q[head_p1]     : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q     <= '0;
      done_q  <= '0;
      for (int i = 0; i < ROB_DEPTH; i++) begin
        pd_q[i]     <= '0;
        old_pd_q[i] <= '0;
        pc_q[i]     <= '0;
      end
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      ovf_q         <= 1'b0;
      ret_valid_1_q <= 1'b0;
      ret_pd_1_q    <= '0;
      ret_old_1_q   <= '0;
      ret_pc_1_q    <= '0;
      ret_valid_2_q <= 1'b0;
      ret_pd_2_q    <= '0;
      ret_old_2_q   <= '0;
      ret_pc_2_q    <= '0;
    end else begin
      v_q           <= v_d;
      done_q        <= done_d;
      pd_q          <= pd_d;
      old_pd_q      <= old_pd_d;
      pc_q          <= pc_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      ovf_q         <= ovf_d;
      ret_valid_1_q <= ret_valid_1_d;
      ret_pd_1_q    <= ret_pd_1_d;
      ret_old_1_q   <= ret_old_1_d;
      ret_pc_1_q    <= ret_pc_1_d;
      ret_valid_2_q <= ret_valid_2_d;
      ret_pd_2_q    <= ret_pd_2_d;
      ret_old_2_q   <= ret_old_2_d;
      ret_pc_2_q    <= ret_pc_2_d;
    end
  end

  assign bus.alloc_ready    = ready;
  assign bus.alloc_idx_1    = idx1;
  assign bus.alloc_idx_2    = idx2;
  assign bus.rob_count      = count_q;
  assign bus.alloc_overflow = ovf_q;
  assign bus.ret_valid_1    = ret_valid_1_q;
  assign bus.ret_pd_1       = ret_pd_1_q;
  assign bus.ret_old_pd_1   = ret_old_1_q;
  assign bus.ret_pc_1       = ret_pc_1_q;
  assign bus.ret_valid_2    = ret_valid_2_q;
  assign bus.ret_pd_2       = ret_pd_2_q;
  assign bus.ret_old_pd_2   = ret_old_2_q;
  assign bus.ret_pc_2       = ret_pc_2_q;
endmodule

// File: tb/tb_rob_retire.sv
// Self-checking bench for rob_retire: a program-order queue model predicts
// retires and status; a monitor compares registered retire outputs each cycle.
module tb_rob_retire;
  logic clk;
  logic rst_n;

  rob_retire_if bus ();

  rob_retire dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  pd;
    logic [5:0]  old;
    logic [31:0] pc;
    bit          done;
  } ent_t;

  ent_t        m_q[$];
  int          m_head;
  bit          m_ovf;
  logic [43:0] exp_q[$];
  int          exp_n_q[$];
  int          n_cmp;
  int          n_fail;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, check status outputs, then advance the model
  // over the coming rising edge and queue the expected retires.
  task automatic drive(input bit v1, input logic [5:0] pd1, input logic [5:0] o1,
                       input logic [31:0] pc1, input bit v2, input logic [5:0] pd2,
                       input logic [5:0] o2, input logic [31:0] pc2,
                       input bit ca, input logic [3:0] ia, input bit cb, input logic [3:0] ib);
    int   tail, n, off, sz;
    bit   rdy;
    ent_t e;
    @(negedge clk);
    bus.alloc_valid_1 = v1; bus.alloc_pd_1 = pd1; bus.alloc_old_pd_1 = o1; bus.alloc_pc_1 = pc1;
    bus.alloc_valid_2 = v2; bus.alloc_pd_2 = pd2; bus.alloc_old_pd_2 = o2; bus.alloc_pc_2 = pc2;
    bus.cmpl_valid_a = ca; bus.cmpl_idx_a = ia;
    bus.cmpl_valid_b = cb; bus.cmpl_idx_b = ib;
    #1;
    sz   = m_q.size();
    tail = (m_head + sz) % 16;
    rdy  = (sz <= 14);
    chk("alloc_ready", 64'(bus.alloc_ready), 64'(rdy));
    chk("alloc_idx_1", 64'(bus.alloc_idx_1), 64'(tail));
    chk("alloc_idx_2", 64'(bus.alloc_idx_2), 64'((tail + int'(v1)) % 16));
    chk("rob_count", 64'(bus.rob_count), 64'(sz));
    chk("alloc_overflow", 64'(bus.alloc_overflow), 64'(m_ovf));

    n = 0;
    if (sz > 0 && m_q[0].done) n = 1;
    if (n == 1 && sz > 1 && m_q[1].done) n = 2;
    if (ca) begin
      off = (int'(ia) - m_head + 16) % 16;
      if (off < sz) m_q[off].done = 1'b1;
    end
    if (cb) begin
      off = (int'(ib) - m_head + 16) % 16;
      if (off < sz) m_q[off].done = 1'b1;
    end
    for (int i = 0; i < n; i++) begin
      e = m_q.pop_front();
      exp_q.push_back({e.pd, e.old, e.pc});
    end
    m_head = (m_head + n) % 16;
    if (v1 || v2) begin
      if (rdy) begin
        if (v1) begin e.pd = pd1; e.old = o1; e.pc = pc1; e.done = 1'b0; m_q.push_back(e); end
        if (v2) begin e.pd = pd2; e.old = o2; e.pc = pc2; e.done = 1'b0; m_q.push_back(e); end
      end else begin
        m_ovf = 1'b1;
      end
    end
    exp_n_q.push_back(n);
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic cmpl(input bit ca, input logic [3:0] ia, input bit cb, input logic [3:0] ib);
    drive(0, 0, 0, 0, 0, 0, 0, 0, ca, ia, cb, ib);
  endtask

  task automatic alloc_rand(input bit v1, input bit v2);
    drive(v1, 6'($urandom), 6'($urandom), $urandom, v2, 6'($urandom), 6'($urandom), $urandom,
          0, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    bus.alloc_valid_1 = 0; bus.alloc_valid_2 = 0; bus.cmpl_valid_a = 0; bus.cmpl_valid_b = 0;
    rst_n = 1'b0;
    #1;
    chk("rst ret_valid_1", 64'(bus.ret_valid_1), 64'd0);
    chk("rst ret_valid_2", 64'(bus.ret_valid_2), 64'd0);
    chk("rst ret_old_pd_1", 64'(bus.ret_old_pd_1), 64'd0);
    chk("rst rob_count", 64'(bus.rob_count), 64'd0);
    chk("rst alloc_ready", 64'(bus.alloc_ready), 64'd1);
    chk("rst alloc_overflow", 64'(bus.alloc_overflow), 64'd0);
    chk("rst alloc_idx_1", 64'(bus.alloc_idx_1), 64'd0);
    chk("rst alloc_idx_2", 64'(bus.alloc_idx_2), 64'd0);
    m_q.delete();
    m_head = 0;
    m_ovf  = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: one expected retire count per modelled edge, data popped in order.
  always @(posedge clk) begin
    int          n;
    logic [43:0] e;
    #1;
    if (rst_n && exp_n_q.size() > 0) begin
      n = exp_n_q.pop_front();
      chk("ret_valid_1", 64'(bus.ret_valid_1), 64'(n >= 1));
      chk("ret_valid_2", 64'(bus.ret_valid_2), 64'(n == 2));
      for (int s = 1; s <= 2; s++) begin
        e = '0;
        if (n >= s && exp_q.size() > 0) e = exp_q.pop_front();
        if (s == 1) chk("ret slot1 data", {20'd0, bus.ret_pd_1, bus.ret_old_pd_1, bus.ret_pc_1}, 64'(e));
        else        chk("ret slot2 data", {20'd0, bus.ret_pd_2, bus.ret_old_pd_2, bus.ret_pc_2}, 64'(e));
      end
    end
  end

  initial begin
    n_cmp = 0; n_fail = 0; m_head = 0; m_ovf = 0;
    rst_n = 1'b0;
    bus.alloc_valid_1 = 0; bus.alloc_pd_1 = 0; bus.alloc_old_pd_1 = 0; bus.alloc_pc_1 = 0;
    bus.alloc_valid_2 = 0; bus.alloc_pd_2 = 0; bus.alloc_old_pd_2 = 0; bus.alloc_pc_2 = 0;
    bus.cmpl_valid_a = 0; bus.cmpl_idx_a = 0; bus.cmpl_valid_b = 0; bus.cmpl_idx_b = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle();

    // Pair ordering: younger completes first, both retire together after the older.
    drive(1, 6'd32, 6'd5, 32'd0, 1, 6'd33, 6'd6, 32'd4, 0, 0, 0, 0);
    cmpl(1, 4'd1, 0, 0);
    cmpl(1, 4'd0, 0, 0);
    repeat (2) idle();

    // Full buffer, then a dropped ninth pair.
    do_reset();
    repeat (8) alloc_rand(1, 1);
    alloc_rand(1, 1);
    idle();
    chk("full rob_count", 64'(bus.rob_count), 64'd16);
    chk("full overflow", 64'(bus.alloc_overflow), 64'd1);
    chk("full ready", 64'(bus.alloc_ready), 64'd0);

    // Stray completion on an empty slot must not mark a later occupant done.
    do_reset();
    cmpl(1, 4'd7, 0, 0);
    repeat (4) alloc_rand(1, 1);
    for (int i = 0; i < 3; i++) cmpl(1, 4'(2 * i), 1, 4'(2 * i + 1));
    cmpl(1, 4'd6, 0, 0);
    repeat (3) idle();
    chk("stray rob_count", 64'(bus.rob_count), 64'd1);
    cmpl(0, 0, 1, 4'd7);
    repeat (2) idle();

    // Wrap: park the head at 15 then retire entries 15 and 0 together.
    do_reset();
    repeat (7) alloc_rand(1, 1);
    alloc_rand(1, 0);
    for (int i = 0; i < 7; i++) cmpl(1, 4'(2 * i), 1, 4'(2 * i + 1));
    cmpl(1, 4'd14, 0, 0);
    repeat (3) idle();
    alloc_rand(1, 1);
    cmpl(1, 4'd15, 1, 4'd0);
    repeat (2) idle();
    chk("wrap alloc_idx_1", 64'(bus.alloc_idx_1), 64'd1);

    // Simultaneous allocate and retire at count 10.
    do_reset();
    repeat (5) alloc_rand(1, 1);
    cmpl(1, 4'd0, 1, 4'd1);
    alloc_rand(1, 1);
    idle();
    chk("simul rob_count", 64'(bus.rob_count), 64'd10);

    // Reset mid-run with five live entries and a retire just presented.
    do_reset();
    repeat (3) alloc_rand(1, 1);
    cmpl(1, 4'd0, 0, 0);
    idle();
    do_reset();

    // Randomised traffic: alternate fill-heavy and drain-heavy phases.
    for (int ph = 0; ph < 6; ph++) begin
      for (int c = 0; c < 100; c++) begin
        int  pa;
        bit  v1, v2;
        pa = (ph % 2 == 0) ? 70 : 25;
        v1 = ($urandom_range(99) < pa);
        v2 = ($urandom_range(99) < pa);
        drive(v1, 6'($urandom), 6'($urandom), $urandom, v2, 6'($urandom), 6'($urandom), $urandom,
              $urandom_range(99) < 60, 4'($urandom), $urandom_range(99) < 60, 4'($urandom));
      end
    end
    repeat (3) idle();
    @(negedge clk);
    chk("scoreboard drained", 64'(exp_q.size() + exp_n_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
